px_scan_scheduler: RTL and testbench

- Sequences the per-pixel oscillator/counter datapath in the clk_px domain.
- Round-robins over the enabled pixels. For each one it enables that pixel's oscillator, holds the pixel counter in clear for a programmable settle time, and accumulates for a programmable window.
- It then freezes all oscillators, captures counter_val into a 2-entry sample FIFO, and moves to the next pixel.
- The downstream transport drains samples with a valid/ready handshake; a full FIFO stalls the scan.

---
 rtl/px_scan_scheduler.sv | 179 +++++++++++++++++
 tb/tb_px_scan_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/px_scan_scheduler.sv
// rtl/px_scan_scheduler.sv - round-robin pixel oscillator/counter scan sequencer
// Settles, accumulates and samples each enabled pixel into a 2-entry output FIFO.
module px_scan_scheduler #(
    parameter int NUM_PX = 24
) (
    input  logic              clk_px,
    input  logic              clr_cntAcc,
    input  logic              start,
    input  logic              continuous,
    input  logic [NUM_PX-1:0] px_mask,
    input  logic [4:0]        settle_cycles,
    input  logic [15:0]       window_cycles,
    input  logic [31:0]       counter_val,
    output logic [4:0]        px_addr,
    output logic [NUM_PX-1:0] stop_osc,
    output logic              clr_counter,
    output logic              sample_valid,
    output logic [31:0]       sample_data,
    output logic [4:0]        sample_px,
    input  logic              sample_ready,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SETTLE, S_ACCUM, S_FREEZE, S_LATCH, S_END
    } state_t;

    localparam logic [4:0] LAST_PX = 5'(NUM_PX - 1);

    state_t            state_q, state_d;
    logic [4:0]        px_addr_q, px_addr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [NUM_PX-1:0] stop_osc_q, stop_osc_d;
    logic              clr_counter_q, clr_counter_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic [31:0]       e0_data_q, e0_data_d, e1_data_q, e1_data_d;
    logic [4:0]        e0_px_q, e0_px_d, e1_px_q, e1_px_d;
    logic [1:0]        count_q, count_d;
    logic [31:0]       mask_ext;
    logic              push, pop;

    assign mask_ext = 32'(px_mask);

    always_comb begin
        state_d   = state_q;
        px_addr_d = px_addr_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        pop       = (count_q != 2'd0) && sample_ready;
        case (state_q)
            S_IDLE: begin
                if (start && (|px_mask)) begin
                    state_d   = S_SELECT;
                    px_addr_d = 5'd0;
                end
            end
            S_SELECT: begin
                if (mask_ext[px_addr_q]) begin
                    state_d = S_SETTLE;
                    cnt_d   = (settle_cycles == 5'd0) ? 16'd0 : 16'(settle_cycles - 5'd1);
                end else if (px_addr_q == LAST_PX) begin
                    state_d   = S_END;
                    px_addr_d = 5'd0;
                end else begin
                    px_addr_d = px_addr_q + 5'd1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_ACCUM;
                    cnt_d   = (window_cycles == 16'd0) ? 16'd0 : window_cycles - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_ACCUM: begin
                if (cnt_q == 16'd0) state_d = S_FREEZE;
                else                cnt_d   = cnt_q - 16'd1;
            end
            S_FREEZE: state_d = S_LATCH;
            S_LATCH: begin
                // Fullness uses the registered count, so a same-cycle pop cannot unblock the write.
                if (count_q != 2'd2) begin
                    push = 1'b1;
                    if (px_addr_q == LAST_PX) begin
                        state_d   = S_END;
                        px_addr_d = 5'd0;
                    end else begin
                        state_d   = S_SELECT;
                        px_addr_d = px_addr_q + 5'd1;
                    end
                end
            end
            S_END: begin
                px_addr_d = 5'd0;
                state_d   = (continuous && (|px_mask)) ? S_SELECT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        stop_osc_d    = (state_d == S_SETTLE || state_d == S_ACCUM) ?
                        ~(NUM_PX'(1) << px_addr_d) : '1;
        clr_counter_d = !(state_d == S_ACCUM || state_d == S_FREEZE || state_d == S_LATCH);
        busy_d        = (state_d != S_IDLE);
        frame_done_d  = (state_d == S_END);

        e0_data_d = e0_data_q;
        e0_px_d   = e0_px_q;
        e1_data_d = e1_data_q;
        e1_px_d   = e1_px_q;
        count_d   = count_q;
        case ({push, pop})
            2'b11: begin
                e0_data_d = counter_val;
                e0_px_d   = px_addr_q;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    e0_data_d = counter_val;
                    e0_px_d   = px_addr_q;
                end else begin
                    e1_data_d = counter_val;
                    e1_px_d   = px_addr_q;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    e0_data_d = e1_data_q;
                    e0_px_d   = e1_px_q;
                end
                count_d = count_q - 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_px or posedge clr_cntAcc) begin
        if (clr_cntAcc) begin
            state_q       <= S_IDLE;
            px_addr_q     <= 5'd0;
            cnt_q         <= 16'd0;
            stop_osc_q    <= '1;
            clr_counter_q <= 1'b1;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            e0_data_q     <= 32'd0;
            e0_px_q       <= 5'd0;
            e1_data_q     <= 32'd0;
            e1_px_q       <= 5'd0;
            count_q       <= 2'd0;
        end else begin
            state_q       <= state_d;
            px_addr_q     <= px_addr_d;
            cnt_q         <= cnt_d;
            stop_osc_q    <= stop_osc_d;
            clr_counter_q <= clr_counter_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            e0_data_q     <= e0_data_d;
            e0_px_q       <= e0_px_d;
            e1_data_q     <= e1_data_d;
            e1_px_q       <= e1_px_d;
            count_q       <= count_d;
        end
    end

    assign px_addr      = px_addr_q;
    assign stop_osc     = stop_osc_q;
    assign clr_counter  = clr_counter_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign sample_valid = (count_q != 2'd0);
    assign sample_data  = e0_data_q;
    assign sample_px    = e0_px_q;

endmodule

// File: tb/tb_px_scan_scheduler.sv
// tb/tb_px_scan_scheduler.sv - directed scoreboard bench for px_scan_scheduler
module tb_px_scan_scheduler;

    localparam int NUM_PX = 24;
    localparam logic [23:0] ALL_ONES = 24'hFFFFFF;

    logic              clk_px = 1'b0;
    logic              clr_cntAcc = 1'b1;
    logic              start = 1'b0;
    logic              continuous = 1'b0;
    logic [NUM_PX-1:0] px_mask = '0;
    logic [4:0]        settle_cycles = 5'd0;
    logic [15:0]       window_cycles = 16'd0;
    logic [31:0]       counter_val;
    logic [4:0]        px_addr;
    logic [NUM_PX-1:0] stop_osc;
    logic              clr_counter;
    logic              sample_valid;
    logic [31:0]       sample_data;
    logic [4:0]        sample_px;
    logic              sample_ready = 1'b0;
    logic              busy;
    logic              frame_done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int t0 = 0;
    int rx_cnt = 0;
    int edges;
    bit osc1_low = 0;
    logic [36:0] exp_q[$];

    px_scan_scheduler #(.NUM_PX(NUM_PX)) dut (
        .clk_px(clk_px), .clr_cntAcc(clr_cntAcc), .start(start), .continuous(continuous),
        .px_mask(px_mask), .settle_cycles(settle_cycles), .window_cycles(window_cycles),
        .counter_val(counter_val), .px_addr(px_addr), .stop_osc(stop_osc),
        .clr_counter(clr_counter), .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_px(sample_px), .sample_ready(sample_ready), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk_px = ~clk_px;
    always @(posedge clk_px) cyc <= cyc + 1;

    assign counter_val = 32'(px_addr) * 32'd100;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_px);
        #1;
    endtask

    task automatic push_frame(input logic [NUM_PX-1:0] m);
        for (int p = 0; p < NUM_PX; p++)
            if (m[p]) exp_q.push_back({5'(p), 32'(p * 100)});
    endtask

    task automatic start_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int bound, output int e);
        bit found = 0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (frame_done) begin
                found = 1;
                break;
            end
        end
        check("frame_done_seen", 64'(found), 64'd1);
        e = cyc - t0;
    endtask

    // Scoreboard: every accepted handshake must match the oldest expected sample.
    always @(negedge clk_px) begin
        if (!clr_cntAcc) begin
            if (!stop_osc[1]) osc1_low = 1;
            if (sample_valid && sample_ready) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_sample", 64'd1, 64'd0);
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    check("sb_px", 64'(sample_px), 64'(e[36:32]));
                    check("sb_data", 64'(sample_data), 64'(e[31:0]));
                end
            end
        end
    end

    initial begin
        step();
        step();
        check("rst_px_addr", 64'(px_addr), 64'd0);
        check("rst_stop_osc", 64'(stop_osc), 64'(ALL_ONES));
        check("rst_clr_counter", 64'(clr_counter), 64'd1);
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        clr_cntAcc = 1'b0;
        step();
        check("idle_busy", 64'(busy), 64'd0);

        // Full frame, S=4 W=10
        px_mask = ALL_ONES; settle_cycles = 5'd4; window_cycles = 16'd10; sample_ready = 1'b1;
        rx_cnt = 0;
        push_frame(ALL_ONES);
        start_frame();
        check("busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < 40 && !sample_valid; i++) step();
        check("first_valid_latency", 64'(cyc - t0), 64'd17);
        check("first_px", 64'(sample_px), 64'd0);
        check("first_data", 64'(sample_data), 64'd0);
        wait_done(1000, edges);
        check("full_frame_done_edge", 64'(edges), 64'd408);
        step();
        check("full_frame_done_pulse", 64'(frame_done), 64'd0);
        check("full_busy_fall", 64'(busy), 64'd0);
        step(); step();
        check("full_rx_cnt", 64'(rx_cnt), 64'd24);
        check("full_sb_empty", 64'(exp_q.size()), 64'd0);

        // Sparse mask 0x5
        px_mask = 24'h000005; rx_cnt = 0; osc1_low = 0;
        push_frame(24'h000005);
        start_frame();
        wait_done(500, edges);
        check("sparse_done_edge", 64'(edges), 64'd56);
        step(); step();
        check("sparse_rx_cnt", 64'(rx_cnt), 64'd2);
        check("sparse_osc1_never_low", 64'(osc1_low), 64'd0);
        check("sparse_sb_empty", 64'(exp_q.size()), 64'd0);

        // Stall with ready low, S=W=0
        px_mask = ALL_ONES; settle_cycles = 5'd0; window_cycles = 16'd0;
        sample_ready = 1'b0; rx_cnt = 0;
        push_frame(ALL_ONES);
        start_frame();
        step();
        check("z_settle_clr", 64'(clr_counter), 64'd1);
        check("z_settle_osc", 64'(stop_osc), 64'(24'hFFFFFE));
        step();
        check("z_accum_clr", 64'(clr_counter), 64'd0);
        check("z_accum_osc", 64'(stop_osc), 64'(24'hFFFFFE));
        step();
        check("z_freeze_osc", 64'(stop_osc), 64'(ALL_ONES));
        check("z_freeze_clr", 64'(clr_counter), 64'd0);
        step();
        check("z_latch_valid_pre", 64'(sample_valid), 64'd0);
        step();
        check("z_latch_valid", 64'(sample_valid), 64'd1);
        check("z_latch_px", 64'(sample_px), 64'd0);
        repeat (25) step();
        check("stall_px_addr", 64'(px_addr), 64'd2);
        check("stall_osc", 64'(stop_osc), 64'(ALL_ONES));
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_head_px", 64'(sample_px), 64'd0);
        check("stall_head_data", 64'(sample_data), 64'd0);
        check("stall_rx_none", 64'(rx_cnt), 64'd0);
        sample_ready = 1'b1;
        wait_done(500, edges);
        step(); step();
        check("stall_rx_cnt", 64'(rx_cnt), 64'd24);
        check("stall_sb_empty", 64'(exp_q.size()), 64'd0);

        // Continuous, two pixels, two frames back to back
        px_mask = 24'h000003; settle_cycles = 5'd1; window_cycles = 16'd1;
        continuous = 1'b1; rx_cnt = 0;
        push_frame(24'h000003);
        push_frame(24'h000003);
        start_frame();
        wait_done(500, edges);
        step();
        check("cont_no_idle_busy", 64'(busy), 64'd1);
        check("cont_px_addr", 64'(px_addr), 64'd0);
        check("cont_done_low", 64'(frame_done), 64'd0);
        continuous = 1'b0;
        t0 = cyc;
        wait_done(500, edges);
        step();
        check("cont_end_busy", 64'(busy), 64'd0);
        step(); step();
        check("cont_rx_cnt", 64'(rx_cnt), 64'd4);
        check("cont_sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset during ACCUM with one sample buffered
        sample_ready = 1'b0; settle_cycles = 5'd2; window_cycles = 16'd5;
        start_frame();
        repeat (14) step();
        check("pre_rst_valid", 64'(sample_valid), 64'd1);
        check("pre_rst_clr", 64'(clr_counter), 64'd0);
        check("pre_rst_osc", 64'(stop_osc), 64'(24'hFFFFFD));
        #2 clr_cntAcc = 1'b1;
        #1;
        check("arst_px_addr", 64'(px_addr), 64'd0);
        check("arst_osc", 64'(stop_osc), 64'(ALL_ONES));
        check("arst_clr", 64'(clr_counter), 64'd1);
        check("arst_valid", 64'(sample_valid), 64'd0);
        check("arst_data", 64'(sample_data), 64'd0);
        check("arst_px", 64'(sample_px), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(frame_done), 64'd0);
        step();
        clr_cntAcc = 1'b0;
        repeat (5) step();
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_valid", 64'(sample_valid), 64'd0);

        // Restart after reset, pixel 0 only
        px_mask = 24'h000001; sample_ready = 1'b1; rx_cnt = 0;
        push_frame(24'h000001);
        start_frame();
        check("restart_busy", 64'(busy), 64'd1);
        wait_done(500, edges);
        step(); step();
        check("restart_rx_cnt", 64'(rx_cnt), 64'd1);
        check("restart_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
